// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the BCD stopwatch.
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUNNING, LAP_HOLD, STOPPED} sw_state_t;
    typedef logic [3:0] bcd_t;
    // Index 5 is the minutes-tens digit and index 0 is the hundredths-units digit.
    typedef bcd_t [5:0] sw_time_t;

    localparam int HUN_MAX   = 9;
    localparam int SEC_T_MAX = 5;
endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit that rolls over at MAX and flags a carry on that roll-over.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);
    assign carry = inc && (q == 4'(MAX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (clr)  q <= '0;
        else if (inc)  q <= carry ? 4'd0 : q + 4'd1;
    end
endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS.hh stopwatch fed by the 100 Hz tick counter, with lap freeze and clear.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     tick,
    input  logic     start_stop,
    input  logic     lap,
    input  logic     clear,
    output sw_time_t digits,
    output logic     running,
    output logic     frozen,
    output logic     wrap,
    output logic     cnt_en,
    output logic     cnt_clr
);
    localparam bcd_t MIN_T = 4'(MAX_MIN / 10);
    localparam bcd_t MIN_U = 4'(MAX_MIN % 10);

    sw_state_t state, nstate;
    logic      do_fresh, do_clr, do_lapin;
    sw_time_t  live, live_nxt, held, held_nxt;
    logic [5:0] inc, carry, dclr;
    logic      min_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nstate;
    end

    // Commands are tested in priority order; an illegal command falls through.
    always_comb begin
        nstate   = state;
        do_fresh = 1'b0;
        do_clr   = 1'b0;
        do_lapin = 1'b0;
        case (state)
            IDLE: if (start_stop) begin
                nstate   = RUNNING;
                do_fresh = 1'b1;
            end
            RUNNING: begin
                if (start_stop) nstate = STOPPED;
                else if (lap) begin
                    nstate   = LAP_HOLD;
                    do_lapin = 1'b1;
                end
            end
            LAP_HOLD: begin
                if (start_stop) nstate = STOPPED;
                else if (lap)   nstate = RUNNING;
            end
            STOPPED: begin
                if (clear) begin
                    nstate = IDLE;
                    do_clr = 1'b1;
                end else if (start_stop) nstate = RUNNING;
            end
            default: nstate = IDLE;
        endcase
    end

    assign running = (state == RUNNING) || (state == LAP_HOLD);
    assign frozen  = (state == LAP_HOLD);
    assign cnt_en  = running;

    // Minutes wrap on the carry out of seconds-tens when already at MAX_MIN.
    assign min_wrap = carry[3] && (live[5] == MIN_T) && (live[4] == MIN_U);

    generate
        for (genvar i = 0; i < 6; i++) begin : g_dig
            if (i == 0) begin : g_first
                assign inc[i] = tick && running;
            end else begin : g_chain
                assign inc[i] = carry[i-1];
            end
            assign dclr[i] = do_clr || ((i >= 4) && min_wrap);

            bcd_digit_counter #(
                .MAX((i == 3) ? SEC_T_MAX : HUN_MAX)
            ) u_dig (
                .clk    (clk),
                .reset_n(reset_n),
                .clr    (dclr[i]),
                .inc    (inc[i]),
                .q      (live[i]),
                .carry  (carry[i])
            );

            // Mirror of the counter's next value so digits can be registered on the same edge.
            assign live_nxt[i] = dclr[i] ? 4'd0 :
                                 inc[i]  ? (carry[i] ? 4'd0 : live[i] + 4'd1) : live[i];
        end
    endgenerate

    assign held_nxt = do_clr ? '0 : do_lapin ? live : held;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held    <= '0;
            digits  <= '0;
            wrap    <= 1'b0;
            cnt_clr <= 1'b1;
        end else begin
            held    <= held_nxt;
            digits  <= (nstate == LAP_HOLD) ? held_nxt : live_nxt;
            wrap    <= min_wrap;
            cnt_clr <= do_fresh || do_clr;
        end
    end
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench: two stopwatches (MAX_MIN 59 and 1) driven by the same stimulus.
module tb_bcd_stopwatch;
    import stopwatch_pkg::*;

    logic     clk = 1'b0;
    logic     reset_n, tick, start_stop, lap, clear;
    sw_time_t digits, digits1;
    logic     running, frozen, wrap, cnt_en, cnt_clr;
    logic     running1, frozen1, wrap1, cnt_en1, cnt_clr1;
    int       checks = 0;
    int       errors = 0;

    always #5 clk = ~clk;

    bcd_stopwatch #(.MAX_MIN(59)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop),
        .lap(lap), .clear(clear), .digits(digits), .running(running),
        .frozen(frozen), .wrap(wrap), .cnt_en(cnt_en), .cnt_clr(cnt_clr)
    );

    bcd_stopwatch #(.MAX_MIN(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start_stop(start_stop),
        .lap(lap), .clear(clear), .digits(digits1), .running(running1),
        .frozen(frozen1), .wrap(wrap1), .cnt_en(cnt_en1), .cnt_clr(cnt_clr1)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) cyc();
        tick = 1'b0;
    endtask

    task automatic cmd(input logic ss, input logic lp, input logic cl, input logic tk);
        start_stop = ss; lap = lp; clear = cl; tick = tk;
        cyc();
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0; tick = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        #12;
        chk("rst_digits", digits, 24'h0);
        chk("rst_cnt_clr", 24'(cnt_clr), 24'h1);
        chk("rst_running", 24'(running), 24'h0);
        chk("rst_wrap", 24'(wrap), 24'h0);
        reset_n = 1'b1;
        cyc();
        chk("rst_cnt_clr_fall", 24'(cnt_clr), 24'h0);

        // Start, cnt_clr pulse, 250 ticks
        cmd(1, 0, 0, 0);
        chk("start_running", 24'(running), 24'h1);
        chk("start_cnt_en", 24'(cnt_en), 24'h1);
        chk("start_cnt_clr", 24'(cnt_clr), 24'h1);
        cyc();
        chk("start_cnt_clr_end", 24'(cnt_clr), 24'h0);
        ticks(250);
        chk("t250", digits, 24'h000250);

        // Full carry chain 00:59.99 -> 01:00.00
        ticks(5749);
        chk("t5999", digits, 24'h005999);
        ticks(1);
        chk("carry_all", digits, 24'h010000);

        cmd(1, 0, 0, 0);
        chk("stop_running", 24'(running), 24'h0);
        cmd(0, 0, 1, 0);
        chk("clr_digits", digits, 24'h0);
        chk("clr_cnt_clr", 24'(cnt_clr), 24'h1);

        // Lap freeze and release
        cmd(1, 0, 0, 0);
        ticks(500);
        chk("pre_lap", digits, 24'h000500);
        cmd(0, 1, 0, 0);
        chk("lap_frozen", 24'(frozen), 24'h1);
        ticks(300);
        chk("lap_hold_digits", digits, 24'h000500);
        chk("lap_hold_running", 24'(running), 24'h1);
        cmd(0, 1, 0, 0);
        chk("lap_release", digits, 24'h000800);
        chk("lap_release_frozen", 24'(frozen), 24'h0);

        // Stop coincident with a tick; ignored ticks; clear
        cmd(1, 0, 0, 0);
        cmd(0, 0, 1, 0);
        cmd(1, 0, 0, 0);
        ticks(9);
        chk("t9", digits, 24'h000009);
        cmd(1, 0, 0, 1);
        chk("stop_tick", digits, 24'h000010);
        chk("stop_tick_running", 24'(running), 24'h0);
        ticks(20);
        chk("stopped_ignore", digits, 24'h000010);
        cmd(0, 0, 1, 0);
        chk("clear_digits", digits, 24'h0);
        chk("clear_cnt_clr", 24'(cnt_clr), 24'h1);
        chk("clear_running", 24'(running), 24'h0);
        ticks(5);
        chk("idle_ignore", digits, 24'h0);

        // Clear beats start_stop in STOPPED
        cmd(1, 0, 0, 0);
        ticks(5);
        cmd(1, 0, 0, 0);
        chk("stopped5", digits, 24'h000005);
        cmd(1, 0, 1, 0);
        chk("prio_digits", digits, 24'h0);
        chk("prio_running", 24'(running), 24'h0);
        chk("prio_cnt_clr", 24'(cnt_clr), 24'h1);

        // Asynchronous reset mid-count
        cmd(1, 0, 0, 0);
        ticks(37);
        chk("pre_reset", digits, 24'h000037);
        #3 reset_n = 1'b0;
        #1;
        chk("async_digits", digits, 24'h0);
        chk("async_cnt_clr", 24'(cnt_clr), 24'h1);
        chk("async_running", 24'(running), 24'h0);
        #3 reset_n = 1'b1;
        cyc();

        // Wrap with MAX_MIN=1 on dut1; dut keeps counting to 02:00.00
        cmd(1, 0, 0, 0);
        cyc();
        ticks(11999);
        chk("w_pre", digits1, 24'h015999);
        chk("w_pre_wrap", 24'(wrap1), 24'h0);
        ticks(1);
        chk("w_digits", digits1, 24'h000000);
        chk("w_wrap", 24'(wrap1), 24'h1);
        chk("w_running", 24'(running1), 24'h1);
        chk("w59_digits", digits, 24'h020000);
        chk("w59_wrap", 24'(wrap), 24'h0);
        cyc();
        chk("w_wrap_end", 24'(wrap1), 24'h0);
        ticks(3);
        chk("w_continue", digits1, 24'h000003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
